// File: rtl/dipsw_debounce.sv
// DIP-switch / pushbutton conditioner: 2-FF synchronizer, per-bit
// stability counters, change strobes and a sticky settled flag.
module dipsw_debounce #(
    parameter int              WIDTH       = 4,
    parameter int              CLK_FREQ    = 12000000,
    parameter int              DEBOUNCE_US = 10000,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_changed,
    output logic             sw_valid
);

    localparam longint DB_CYCLES =
        (64'(CLK_FREQ) * 64'(DEBOUNCE_US)) / 64'd1000000;
    localparam int CW = $clog2(DB_CYCLES + 3);

    localparam logic [CW-1:0] DB_MAX     = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(DB_CYCLES + 2);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("dipsw_debounce: DB_CYCLES must be >= 2");
    end

    logic [WIDTH-1:0]         sync1_q, sync2_q;
    logic [WIDTH-1:0]         sw_out_q, sw_out_d;
    logic [WIDTH-1:0]         chg_q, chg_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]            settle_q, settle_d;
    logic                     valid_q, valid_d;
    logic                     cnt_idle;

    always_comb begin
        sw_out_d = sw_out_q;
        cnt_d    = cnt_q;
        chg_d    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == sw_out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_MAX) begin
                sw_out_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                chg_d[i]    = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_comb begin
        cnt_idle = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q[i] != '0) cnt_idle = 1'b0;
        end
        settle_d = (settle_q == SETTLE_MAX) ? settle_q
                                            : settle_q + CW'(1);
        // Sticky: once settled, later switch activity never clears it.
        valid_d  = valid_q
                 | ((settle_q == SETTLE_MAX)
                    && (sync2_q == sw_out_q)
                    && cnt_idle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= RESET_VAL;
            sync2_q  <= RESET_VAL;
            sw_out_q <= RESET_VAL;
            chg_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            sync1_q  <= sw_raw;
            sync2_q  <= sync1_q;
            sw_out_q <= sw_out_d;
            chg_q    <= chg_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            valid_q  <= valid_d;
        end
    end

    assign sw_out     = sw_out_q;
    assign sw_changed = chg_q;
    assign sw_valid   = valid_q;

endmodule

// File: tb/tb_dipsw_debounce.sv
// Directed bench for dipsw_debounce with DB_CYCLES = 4.
module tb_dipsw_debounce;

    logic       clk;
    logic       rst;
    logic [3:0] sw_raw;
    logic [3:0] sw_out;
    logic [3:0] sw_changed;
    logic       sw_valid;

    int n_pass;
    int n_total;

    dipsw_debounce #(
        .WIDTH      (4),
        .CLK_FREQ   (1000000),
        .DEBOUNCE_US(4),
        .RESET_VAL  (4'b0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .sw_out    (sw_out),
        .sw_changed(sw_changed),
        .sw_valid  (sw_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_out;
        logic       exp_v;
        rst    = 1'b1;
        sw_raw = 4'b0000;
        repeat (3) tick();
        n_total++;
        if ({sw_out, sw_changed, sw_valid} !== 9'b0) begin
            $display("FAIL reset_state: got out=%b chg=%b v=%b want 0/0/0",
                     sw_out, sw_changed, sw_valid);
        end else n_pass++;
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_out = 4'b0000;
            exp_v   = (e >= 7);
            n_total++;
            if (sw_out !== exp_out || sw_changed !== 4'b0000
                || sw_valid !== exp_v) begin
                $display("FAIL settle_e%0d: got out=%b chg=%b v=%b want %b/0000/%b",
                         e, sw_out, sw_changed, sw_valid, exp_out, exp_v);
            end else n_pass++;
        end
    endtask

    task automatic test_latency();
        logic [3:0] exp_out, exp_chg;
        sw_raw = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_out = (e >= 6) ? 4'b0001 : 4'b0000;
            exp_chg = (e == 6) ? 4'b0001 : 4'b0000;
            n_total++;
            if (sw_out !== exp_out || sw_changed !== exp_chg) begin
                $display("FAIL latency_e%0d: got out=%b chg=%b want %b/%b",
                         e, sw_out, sw_changed, exp_out, exp_chg);
            end else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad    = 0;
        sw_raw = 4'b0011;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) sw_raw = 4'b0001;
            if (sw_out !== 4'b0001 || sw_changed !== 4'b0000
                || sw_valid !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0) begin
            $display("FAIL glitch: got %0d bad cycles, out=%b chg=%b v=%b want 0",
                     bad, sw_out, sw_changed, sw_valid);
        end else n_pass++;
    endtask

    task automatic test_bounce();
        int strobes;
        strobes = 0;
        for (int p = 0; p < 4; p++) begin
            sw_raw = (p % 2 == 0) ? 4'b0101 : 4'b0001;
            repeat (2) begin
                tick();
                if (sw_changed[2]) strobes++;
            end
        end
        n_total++;
        if (sw_out !== 4'b0001) begin
            $display("FAIL bounce_hold: got out=%b want 0001", sw_out);
        end else n_pass++;
        sw_raw = 4'b0101;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (sw_changed[2]) strobes++;
            if (e == 5) begin
                n_total++;
                if (sw_out !== 4'b0001) begin
                    $display("FAIL bounce_e5: got out=%b want 0001", sw_out);
                end else n_pass++;
            end
            if (e == 6) begin
                n_total++;
                if (sw_out !== 4'b0101 || sw_changed !== 4'b0100) begin
                    $display("FAIL bounce_e6: got out=%b chg=%b want 0101/0100",
                             sw_out, sw_changed);
                end else n_pass++;
            end
        end
        n_total++;
        if (strobes != 1) begin
            $display("FAIL bounce_strobes: got %0d want 1", strobes);
        end else n_pass++;
    endtask

    task automatic test_multi();
        logic [3:0] exp_out, exp_chg;
        sw_raw = 4'b1100;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_out = (e >= 6) ? 4'b1100 : 4'b0101;
            exp_chg = (e == 6) ? 4'b1001 : 4'b0000;
            n_total++;
            if (sw_out !== exp_out || sw_changed !== exp_chg
                || sw_valid !== 1'b1) begin
                $display("FAIL multi_e%0d: got out=%b chg=%b v=%b want %b/%b/1",
                         e, sw_out, sw_changed, sw_valid, exp_out, exp_chg);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_out, exp_chg;
        logic       exp_v;
        sw_raw = 4'b1111;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        n_total++;
        if (sw_out !== 4'b0000 || sw_changed !== 4'b0000
            || sw_valid !== 1'b0) begin
            $display("FAIL midrst_async: got out=%b chg=%b v=%b want 0000/0000/0",
                     sw_out, sw_changed, sw_valid);
        end else n_pass++;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_out = (e >= 6) ? 4'b1111 : 4'b0000;
            exp_chg = (e == 6) ? 4'b1111 : 4'b0000;
            exp_v   = (e >= 7);
            n_total++;
            if (sw_out !== exp_out || sw_changed !== exp_chg
                || sw_valid !== exp_v) begin
                $display("FAIL midrst_e%0d: got out=%b chg=%b v=%b want %b/%b/%b",
                         e, sw_out, sw_changed, sw_valid,
                         exp_out, exp_chg, exp_v);
            end else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        sw_raw  = 4'b0000;
        test_reset();
        test_latency();
        test_glitch();
        test_bounce();
        test_multi();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dipsw_debounce.md
Name: dipsw_debounce

Overview:
Upstream conditioning stage for the DIP-switch and pushbutton inputs. It feeds the clock-source select and the LED pattern-select logic with clean, synchronized levels. Each raw asynchronous input bit passes through a 2-FF synchronizer and then a per-bit stability counter. A debounced output bit changes only after its input has held a new level for a full debounce period. The block also provides per-bit one-cycle change strobes and a sticky "outputs settled after reset" flag.

Parameters:
WIDTH, 4, number of switch bits debounced independently (1..16)
CLK_FREQ, 12000000, clk frequency in Hz
DEBOUNCE_US, 10000, required stable time in microseconds
RESET_VAL, 0 (WIDTH bits), value loaded into synchronizers and sw_out on reset
(derived) DB_CYCLES = (CLK_FREQ*DEBOUNCE_US)/1000000, 64-bit evaluation, truncated; must be >= 2, enforced by elaboration-time check
(derived) CW = clog2(DB_CYCLES+3), width of the per-bit and settle counters

Ports:
clk  input  1  single clock for all logic (12 MHz board clock)
rst  input  1  asynchronous, active-high reset
sw_raw  input  WIDTH  raw switch levels, asynchronous to clk
sw_out  output  WIDTH  debounced, registered switch levels
sw_changed  output  WIDTH  per-bit strobe, high for exactly one cycle when the matching sw_out bit toggles
sw_valid  output  1  sticky flag: sw_out reflects settled inputs since the last reset

Behaviour:
- Reset (rst=1, async assert; all state in the clk domain):
  - sync1, sync2 and sw_out = RESET_VAL
  - all bit counters and the settle counter = 0
  - sw_changed = 0, sw_valid = 0
- Synchronizer: sync1 <= sw_raw, sync2 <= sync1 every edge. sync2 is the only consumer of sw_raw.
- Per-bit debounce, bit i, evaluated every edge:
  - sync2[i] == sw_out[i]: cnt[i] <= 0; sw_out[i] holds.
  - Mismatch and cnt[i] < DB_CYCLES-1: cnt[i] <= cnt[i]+1.
  - Mismatch and cnt[i] == DB_CYCLES-1: sw_out[i] <= sync2[i], cnt[i] <= 0, sw_changed[i] <= 1.
  - In all other cases sw_changed[i] <= 0. The strobe is registered and coincides with the first cycle the new sw_out value is visible.
- Latency: a raw level first sampled into sync1 at edge N, and held, appears on sw_out at edge N+1+DB_CYCLES.
- Glitch and bounce rejection: any return to agreement before the counter completes clears the counter. Pulses shorter than DB_CYCLES cycles, as seen at sync2, never propagate. Bouncing restarts the period from the last transition.
- Bits are fully independent. Simultaneous qualifying changes on several bits produce multi-hot sw_changed in the same cycle.
- Settle counter:
  - Increments from 0 after reset, saturating at DB_CYCLES+2.
  - sw_valid <= 1 at the first edge where the settle counter is saturated, sync2 == sw_out on all bits, and all cnt[i] == 0.
  - sw_valid stays high until the next reset and is not cleared by later switch activity.
- Reset mid-operation: in-progress counts are discarded with no strobe, and sw_out returns to RESET_VAL. After release, an input still differing from RESET_VAL debounces normally and strobes.
- Counter wrap: counters never exceed DB_CYCLES-1 (bit) or DB_CYCLES+2 (settle), so no wrap is possible.
- No combinational path from any input to any output.

Test Plan (override CLK_FREQ=1000000, DEBOUNCE_US=4, so DB_CYCLES=4; WIDTH=4, RESET_VAL=0):
1. Assert rst, hold sw_raw=0, release rst -> sw_out=0 and sw_changed=0 throughout; sw_valid rises on the 7th edge after release (settle saturates at 6, then all-match check) and stays 1.
2. sw_raw[0] 0->1 first sampled at edge N, held -> sw_out=4'b0001 from edge N+5; sw_changed=4'b0001 for exactly the cycle after edge N+5, then 0.
3. sw_raw[1] high for 3 clk cycles, then low -> sw_out[1] stays 0, sw_changed never asserts, sw_valid stays 1.
4. sw_raw[2] bounces 1,0,1,0,1 (2 cycles each), then holds 1 -> single sw_changed[2] strobe; sw_out[2]=1 exactly 5 edges after the last 0->1 sample edge.
5. sw_raw[3] and sw_raw[0] both toggle on the same cycle and hold -> sw_changed=4'b1001 in one cycle; both sw_out bits update on the same edge.
6. sw_raw=4'b1111 held; assert rst when cnt=2 -> immediate sw_out=0, sw_valid=0, sw_changed=0. After release, sw_out=4'b1111 with sw_changed=4'b1111 at release+6 edges; sw_valid rises after settle and match.
